// File: rtl/rv32i_types.sv
// Shared type definitions for the pmem arbiter: FSM states and the latched D-side operation.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } arb_state_t;

    typedef enum logic {
        ARB_RD,
        ARB_WR
    } arb_op_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of D grants issued while the I-cache was left waiting.
// Instantiated by cache_arbiter only when ARB_STARVE_GUARD_EN is defined.
module arb_starve_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(MAX))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == CW'(MAX));

endmodule

// File: rtl/cache_arbiter.sv
// Shares one pmem line port between the I-cache and D-cache miss paths, D first by default.
// Optional I-starvation guard: define ARB_STARVE_GUARD_EN.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_W     = 256,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arb_grant_d
);

    arb_state_t        state_q, state_d;
    arb_op_t           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic i_req, d_req, i_prio, grant_i, grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_STARVE_GUARD_EN
    logic starve_sat;

    arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (grant_d & i_req),
        .clr_i (grant_i),
        .sat_o (starve_sat)
    );

    assign i_prio = starve_sat;
`else
    logic unused_starve_max;
    assign unused_starve_max = (STARVE_MAX != 0);
    assign i_prio            = 1'b0;
`endif

    assign grant_i = (state_q == IDLE) & i_req & (~d_req | i_prio);
    assign grant_d = (state_q == IDLE) & d_req & ~grant_i;

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= ARB_RD;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = SERVE_I;
                end else if (grant_d) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: if (pmem_resp) state_d = RELEASE;
            RELEASE:          state_d = IDLE;
            default:          state_d = IDLE;
        endcase
        if (grant_i || grant_d) begin
            addr_d  = grant_i ? i_pmem_address : d_pmem_address;
            wdata_d = d_pmem_wdata;
            op_d    = (grant_d && d_pmem_write) ? ARB_WR : ARB_RD;
        end
    end

    always_comb begin
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        arb_grant_d = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (state_q)
            SERVE_I: begin
                pmem_read   = 1'b1;
                i_pmem_resp = pmem_resp;
            end
            SERVE_D: begin
                arb_grant_d = 1'b1;
                pmem_read   = (op_q == ARB_RD);
                pmem_write  = (op_q == ARB_WR);
                d_pmem_resp = pmem_resp;
            end
            default: ;
        endcase
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    // A simultaneous D read+write is resolved as a write, but it is a D-cache bug.
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE) |-> !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized and directed bench for cache_arbiter against a transaction-level reference model.
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int SMAX = 2;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic          arb_grant_d;

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(SMAX)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .arb_grant_d    (arb_grant_d)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns memory (0 none, 1 I, 2 D), what was latched, cycles of gap left.
    int            m_owner = 0;
    bit            m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wdata = '0;
    int            m_gap = 0;
    int            m_starve = 0;
    int            grant_log[$];

    task model_update();
        bit i_wins;
        bit d_pend;
        d_pend = d_pmem_read || d_pmem_write;
        if (rst) begin
            m_owner  = 0;
            m_gap    = 0;
            m_starve = 0;
        end else if (m_owner != 0) begin
            if (pmem_resp) begin
                m_owner = 0;
                m_gap   = 1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (i_pmem_read || d_pend) begin
            i_wins  = i_pmem_read && (!d_pend || (GUARD && m_starve == SMAX));
            m_wdata = d_pmem_wdata;
            if (i_wins) begin
                m_owner  = 1;
                m_wr     = 1'b0;
                m_addr   = i_pmem_address;
                m_starve = 0;
            end else begin
                m_owner = 2;
                m_wr    = d_pmem_write;
                m_addr  = d_pmem_address;
                if (i_pmem_read && m_starve < SMAX) m_starve++;
            end
            grant_log.push_back(m_owner);
        end
    endtask

    always @(negedge clk) begin
        check("pmem_read", pmem_read, (m_owner == 1) || (m_owner == 2 && !m_wr));
        check("pmem_write", pmem_write, (m_owner == 2) && m_wr);
        check("arb_grant_d", arb_grant_d, m_owner == 2);
        check("i_resp", i_pmem_resp, pmem_resp && (m_owner == 1));
        check("d_resp", d_pmem_resp, pmem_resp && (m_owner == 2));
        check("i_rdata", i_pmem_rdata, pmem_rdata);
        check("d_rdata", d_pmem_rdata, pmem_rdata);
        if (m_owner != 0) begin
            check("pmem_address", pmem_address, m_addr);
            if (m_owner == 2 && m_wr) check("pmem_wdata", pmem_wdata, m_wdata);
        end
        model_update();
    end

    // Memory: answers each strobe after a latency, may pulse spuriously when idle, aborts on rst.
    int mem_lat = 3;
    bit mem_rand_lat = 1'b0;
    bit spur_en = 1'b0;
    bit spur_force = 1'b0;
    bit mem_busy = 1'b0;
    int mem_cnt = 0;

    always @(posedge clk) begin
        #2;
        pmem_rdata = {8{$urandom()}};
        pmem_resp  = 1'b0;
        if (rst) begin
            mem_busy = 1'b0;
        end else begin
            if (!mem_busy && (pmem_read || pmem_write)) begin
                mem_busy = 1'b1;
                mem_cnt  = mem_rand_lat ? int'($urandom_range(1, 6)) : mem_lat;
            end
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    pmem_resp = 1'b1;
                    mem_busy  = 1'b0;
                end
            end else if (spur_force || (spur_en && $urandom_range(0, 7) == 0)) begin
                pmem_resp = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_i(input logic [AW-1:0] addr);
        bit got = 1'b0;
        i_pmem_read    = 1'b1;
        i_pmem_address = addr;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            got = i_pmem_resp;
        end
        check("i_done", got, 1'b1);
        step();
        i_pmem_read = 1'b0;
    endtask

    task automatic do_d(input logic [AW-1:0] addr, input bit wr, input logic [LW-1:0] wdata);
        bit got = 1'b0;
        d_pmem_read    = !wr;
        d_pmem_write   = wr;
        d_pmem_address = addr;
        d_pmem_wdata   = wdata;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            got = d_pmem_resp;
        end
        check("d_done", got, 1'b1);
        step();
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_line_addr();
        return $urandom() & 32'hFFFF_FFE0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_log[$];
        bit got;

        repeat (2) step();
        rst = 1'b0;
        step();

        // Lone I read, latency 5
        mem_lat = 5;
        grant_log.delete();
        do_i(32'h0000_0060);
        check("t1_grants", grant_log.size(), 1);
        check("t1_who", grant_log[0], 1);
        repeat (2) step();

        // Simultaneous I and D reads: D first
        mem_lat = 3;
        grant_log.delete();
        fork
            do_i(32'h100);
            do_d(32'h200, 1'b0, '0);
        join
        check("t2_grants", grant_log.size(), 2);
        check("t2_first", grant_log[0], 2);
        check("t2_second", grant_log[1], 1);
        repeat (2) step();

        // D writeback then D read of the same line while I waits
        grant_log.delete();
        fork
            do_i(32'h100);
            begin
                do_d(32'h300, 1'b1, {32{8'hA5}});
                do_d(32'h300, 1'b0, '0);
            end
        join
        exp_log = '{2, 2, 1};
        check("t3_grants", grant_log.size(), exp_log.size());
        foreach (exp_log[k]) check("t3_order", grant_log[k], exp_log[k]);
        repeat (2) step();

        // D requesting back-to-back with I pending
        grant_log.delete();
        fork
            do_i(32'h400);
            repeat (4) do_d(rand_line_addr(), 1'($urandom_range(0, 1)), {8{$urandom()}});
        join
        if (GUARD) exp_log = '{2, 2, 1, 2, 2};
        else       exp_log = '{2, 2, 2, 2, 1};
        check("t4_grants", grant_log.size(), exp_log.size());
        foreach (exp_log[k]) check("t4_order", grant_log[k], exp_log[k]);
        repeat (2) step();

        // Spurious memory response while idle
        spur_force = 1'b1;
        step();
        spur_force = 1'b0;
        step();
        grant_log.delete();
        do_i(32'h500);
        check("t5_grants", grant_log.size(), 1);
        repeat (2) step();

        // Reset two cycles into SERVE_D, then a pending I request
        mem_lat = 10;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h600;
        d_pmem_wdata   = {8{32'hDEAD_BEEF}};
        step();
        step();
        rst            = 1'b1;
        d_pmem_read    = 1'b0;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h700;
        @(negedge clk);
        check("t6_pre_grant_d", arb_grant_d, 1'b1);
        @(negedge clk);
        check("t6_rst_read", pmem_read, 1'b0);
        check("t6_rst_write", pmem_write, 1'b0);
        check("t6_rst_addr", pmem_address, '0);
        check("t6_rst_wdata", pmem_wdata, '0);
        check("t6_rst_grant", arb_grant_d, 1'b0);
        check("t6_rst_iresp", i_pmem_resp, 1'b0);
        check("t6_rst_dresp", d_pmem_resp, 1'b0);
        step();
        rst = 1'b0;
        mem_lat = 3;
        grant_log.delete();
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = i_pmem_resp;
        end
        check("t6_i_done", got, 1'b1);
        check("t6_grants", grant_log.size(), 1);
        check("t6_who", grant_log[0], 1);
        step();
        i_pmem_read = 1'b0;
        repeat (2) step();

        // Randomized traffic with random latency and spurious responses
        mem_rand_lat = 1'b1;
        spur_en      = 1'b1;
        fork
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) step();
                do_i(rand_line_addr());
            end
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 2)) step();
                do_d(rand_line_addr(), 1'($urandom_range(0, 1)), {8{$urandom()}});
            end
        join
        spur_en = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
